// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Two-port (instruction fetch / data) arbiter onto a single
//             synchronous memory port. Round-robin on contention, one access
//             per two cycles, ready pulse exactly one cycle after issue.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter (
    input  logic        clk,
    input  logic        n_reset,
    // instruction-fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    // memory port
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    // statistics
    output logic [15:0] conflicts
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_I_WAIT = 2'd1;
    localparam logic [1:0] S_D_WAIT = 2'd2;

    localparam logic       c_GRANT_I = 1'b0;
    localparam logic       c_GRANT_D = 1'b1;

    localparam logic [15:0] c_CONF_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic        r_last_grant;
    logic        r_d_we;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic [15:0] r_conflicts;

    logic        w_idle;
    logic        w_both;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_issue_i;
    logic        w_issue_d;
    logic [31:0] w_d_load;

    // Issue decode. n_reset gates the strobe so the memory port is quiet
    // while reset is held even if requests are already asserted.
    always_comb begin
        w_idle    = (r_state == S_IDLE) && n_reset;
        w_both    = i_req && d_req;
        // Data wins when it is alone, or on contention when fetch went last.
        w_grant_d = d_req && (!i_req || (r_last_grant == c_GRANT_I));
        w_grant_i = i_req && !w_grant_d;
        w_issue_i = w_idle && w_grant_i;
        w_issue_d = w_idle && w_grant_d;
    end

    // Memory-port drive: address/data only in the issue cycle, zero otherwise.
    always_comb begin
        m_en    = w_issue_i || w_issue_d;
        m_we    = w_issue_d && d_we;
        m_addr  = w_issue_d ? d_addr : (w_issue_i ? i_addr : 32'd0);
        m_wdata = w_issue_d ? d_wdata : 32'd0;
    end

    // Completion outputs. Read data passes straight through during the ready
    // cycle (memory data arrives that cycle) and is held in a register after.
    always_comb begin
        i_ready   = (r_state == S_I_WAIT);
        d_ready   = (r_state == S_D_WAIT);
        w_d_load  = r_d_we ? 32'd0 : m_rdata;
        i_rdata   = i_ready ? m_rdata  : r_i_rdata;
        d_rdata   = d_ready ? w_d_load : r_d_rdata;
        conflicts = r_conflicts;
    end

    // State, grant history, captured write flag and held read data.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_GRANT_I;
            r_d_we       <= 1'b0;
            r_i_rdata    <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue_d) begin
                        r_state      <= S_D_WAIT;
                        r_last_grant <= c_GRANT_D;
                        r_d_we       <= d_we;
                    end else if (w_issue_i) begin
                        r_state      <= S_I_WAIT;
                        r_last_grant <= c_GRANT_I;
                    end
                end
                S_I_WAIT: begin
                    r_i_rdata <= m_rdata;
                    r_state   <= S_IDLE;
                end
                S_D_WAIT: begin
                    r_d_rdata <= w_d_load;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Contention counter: one count per contended issue, saturating.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_conflicts <= 16'd0;
        end else if (w_idle && w_both && (r_conflicts != c_CONF_MAX)) begin
            r_conflicts <= r_conflicts + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter: a directed vector table
//             applied cycle by cycle, plus hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [15:0] conflicts;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .conflicts (conflicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] m_rdata;
        logic        e_m_en;
        logic        e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic        e_i_ready;
        logic [31:0] e_i_rdata;
        logic        e_d_ready;
        logic [31:0] e_d_rdata;
        logic [15:0] e_conf;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        m_rdata = 32'd0;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fields: i_req i_addr d_req d_we d_addr d_wdata m_rdata |
        //         m_en m_we m_addr m_wdata i_ready i_rdata d_ready d_rdata conflicts
        vecs[0]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0,   32'h0,     32'h0,
                     1'b1, 1'b0, 32'h4,   32'h0,     1'b0, 32'h0,  1'b0, 32'h0,        16'd0};
        vecs[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0,   32'h0,     32'h13,
                     1'b0, 1'b0, 32'h0,   32'h0,     1'b1, 32'h13, 1'b0, 32'h0,        16'd0};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   32'h1FE,   32'hDEAD,
                     1'b1, 1'b1, 32'h0,   32'h1FE,   1'b0, 32'h13, 1'b0, 32'h0,        16'd0};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   32'h1FE,   32'hDEAD,
                     1'b0, 1'b0, 32'h0,   32'h0,     1'b0, 32'h13, 1'b1, 32'h0,        16'd0};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'hAAAA,  32'h0,
                     1'b1, 1'b0, 32'h100, 32'hAAAA,  1'b0, 32'h13, 1'b0, 32'h0,        16'd0};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,     32'hCAFEF00D,
                     1'b0, 1'b0, 32'h0,   32'h0,     1'b0, 32'h13, 1'b1, 32'hCAFEF00D, 16'd0};
        vecs[6]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h200, 32'h55,    32'h0,
                     1'b1, 1'b0, 32'h8,   32'h0,     1'b0, 32'h13, 1'b0, 32'hCAFEF00D, 16'd0};
        vecs[7]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h200, 32'h55,    32'h11,
                     1'b0, 1'b0, 32'h0,   32'h0,     1'b1, 32'h11, 1'b0, 32'hCAFEF00D, 16'd1};
        vecs[8]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h200, 32'h55,    32'h0,
                     1'b1, 1'b0, 32'h200, 32'h55,    1'b0, 32'h11, 1'b0, 32'hCAFEF00D, 16'd1};
        vecs[9]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h200, 32'h55,    32'h22,
                     1'b0, 1'b0, 32'h0,   32'h0,     1'b0, 32'h11, 1'b1, 32'h22,       16'd2};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,     32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,     1'b0, 32'h11, 1'b0, 32'h22,       16'd2};

        // ---- reset state, with both requests already high -------------------
        n_reset = 1'b0;
        idle_inputs();
        i_req = 1'b1;
        d_req = 1'b1;
        @(negedge clk);
        #1;
        chk("rst m_en",      {31'd0, m_en},     32'd0);
        chk("rst m_we",      {31'd0, m_we},     32'd0);
        chk("rst i_ready",   {31'd0, i_ready},  32'd0);
        chk("rst d_ready",   {31'd0, d_ready},  32'd0);
        chk("rst i_rdata",   i_rdata,           32'd0);
        chk("rst d_rdata",   d_rdata,           32'd0);
        chk("rst conflicts", {16'd0, conflicts}, 32'd0);
        @(negedge clk);
        idle_inputs();
        n_reset = 1'b1;

        // ---- vector table ------------------------------------------------------
        for (int v = 0; v < NV; v++) begin
            i_req   = vecs[v].i_req;
            i_addr  = vecs[v].i_addr;
            d_req   = vecs[v].d_req;
            d_we    = vecs[v].d_we;
            d_addr  = vecs[v].d_addr;
            d_wdata = vecs[v].d_wdata;
            m_rdata = vecs[v].m_rdata;
            #1;
            chk($sformatf("v%0d m_en", v),      {31'd0, m_en},      {31'd0, vecs[v].e_m_en});
            chk($sformatf("v%0d m_we", v),      {31'd0, m_we},      {31'd0, vecs[v].e_m_we});
            chk($sformatf("v%0d m_addr", v),    m_addr,             vecs[v].e_m_addr);
            chk($sformatf("v%0d m_wdata", v),   m_wdata,            vecs[v].e_m_wdata);
            chk($sformatf("v%0d i_ready", v),   {31'd0, i_ready},   {31'd0, vecs[v].e_i_ready});
            chk($sformatf("v%0d i_rdata", v),   i_rdata,            vecs[v].e_i_rdata);
            chk($sformatf("v%0d d_ready", v),   {31'd0, d_ready},   {31'd0, vecs[v].e_d_ready});
            chk($sformatf("v%0d d_rdata", v),   d_rdata,            vecs[v].e_d_rdata);
            chk($sformatf("v%0d conflicts", v), {16'd0, conflicts}, {16'd0, vecs[v].e_conf});
            @(negedge clk);
        end

        // ---- continuous contention from reset: D,I,D,I ------------------------
        do_reset();
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 32'h40;
        d_addr = 32'h80;
        begin
            logic gd;
            gd = 1'b0;
            for (int k = 0; k < 8; k++) begin
                m_rdata = 32'h1000 + k;
                #1;
                if ((k % 2) == 0) begin
                    gd = (((k >> 1) & 1) == 0);
                    chk($sformatf("rr%0d m_en", k),    {31'd0, m_en},    32'd1);
                    chk($sformatf("rr%0d m_addr", k),  m_addr,           gd ? 32'h80 : 32'h40);
                    chk($sformatf("rr%0d i_ready", k), {31'd0, i_ready}, 32'd0);
                    chk($sformatf("rr%0d d_ready", k), {31'd0, d_ready}, 32'd0);
                end else begin
                    chk($sformatf("rr%0d m_en", k),    {31'd0, m_en},    32'd0);
                    chk($sformatf("rr%0d i_ready", k), {31'd0, i_ready}, {31'd0, !gd});
                    chk($sformatf("rr%0d d_ready", k), {31'd0, d_ready}, {31'd0, gd});
                end
                @(negedge clk);
            end
        end
        #1;
        chk("rr conflicts", {16'd0, conflicts}, 32'd4);

        // ---- asynchronous reset during D_WAIT ---------------------------------
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h300;
        #1;
        chk("ar issue m_en", {31'd0, m_en}, 32'd1);
        @(posedge clk);
        #2;
        d_req   = 1'b0;
        n_reset = 1'b0;
        #1;
        chk("ar d_ready",   {31'd0, d_ready},   32'd0);
        chk("ar m_en",      {31'd0, m_en},      32'd0);
        chk("ar m_addr",    m_addr,             32'd0);
        chk("ar conflicts", {16'd0, conflicts}, 32'd0);
        chk("ar d_rdata",   d_rdata,            32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("ar post%0d d_ready", k), {31'd0, d_ready}, 32'd0);
            chk($sformatf("ar post%0d i_ready", k), {31'd0, i_ready}, 32'd0);
            @(negedge clk);
        end
        i_req  = 1'b1;
        i_addr = 32'h500;
        #1;
        chk("ar next m_en",   {31'd0, m_en}, 32'd1);
        chk("ar next m_addr", m_addr,        32'h500);
        @(negedge clk);
        m_rdata = 32'h77;
        #1;
        chk("ar next i_ready", {31'd0, i_ready}, 32'd1);
        chk("ar next i_rdata", i_rdata,          32'h77);
        @(negedge clk);
        idle_inputs();

        // ---- conflict counter saturation --------------------------------------
        force dut.r_conflicts = 16'hFFFF;
        #1;
        release dut.r_conflicts;
        #1;
        chk("sat preset", {16'd0, conflicts}, 32'hFFFF);
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 32'h700;
        d_addr = 32'h704;
        #1;
        chk("sat issue m_addr", m_addr, 32'h704);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sat d_ready",   {31'd0, d_ready},   32'd1);
        chk("sat conflicts", {16'd0, conflicts}, 32'hFFFF);
        @(negedge clk);

        // ---- request dropped during I_WAIT ------------------------------------
        i_req  = 1'b1;
        i_addr = 32'h600;
        #1;
        chk("drop issue m_en", {31'd0, m_en}, 32'd1);
        @(negedge clk);
        i_req   = 1'b0;
        m_rdata = 32'h99;
        #1;
        chk("drop i_ready", {31'd0, i_ready}, 32'd1);
        chk("drop i_rdata", i_rdata,          32'h99);
        @(negedge clk);
        m_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("drop after%0d i_ready", k), {31'd0, i_ready}, 32'd0);
            chk($sformatf("drop after%0d m_en", k),    {31'd0, m_en},    32'd0);
            chk($sformatf("drop after%0d i_rdata", k), i_rdata,          32'h99);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
